// File: rtl/chacha_core_sched.sv
// Round-robin scheduler sharing one ChaCha20 block core between NUM_REQ requesters.
// Define CHACHA_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module chacha_core_sched #(
  parameter int          NUM_REQ        = 4,
  parameter logic [31:0] COUNTER_INIT   = 32'd1,
  parameter int          TIMEOUT_CYCLES = 1024,
  localparam int         SELW           = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [NUM_REQ-1:0] ctx_clear,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic [NUM_REQ-1:0] exhausted,
  output logic [SELW-1:0]    core_sel,
  output logic               core_start,
  input  logic               core_done,
  output logic [31:0]        counter_out,
  output logic               busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RELEASE} state_t;

  state_t             r_state, w_next;
  logic [SELW-1:0]    r_sel;
  logic [31:0]        r_ctr [NUM_REQ];
  logic [NUM_REQ-1:0] r_exh;
  logic [NUM_REQ-1:0] r_grant, r_ack, r_err;
  logic [SELW-1:0]    r_core_sel;
  logic               r_start;
  logic [31:0]        r_cnt_out;
  logic [TW-1:0]      r_timer;
  logic [NUM_REQ-1:0] w_elig;
  logic [SELW-1:0]    w_pick, w_idx;
  logic               w_any;
  logic               w_timeout;

`ifndef CHACHA_SCHED_FIXED_PRIO_EN
  logic [SELW-1:0]    r_rr;
`endif

  assign w_elig      = req & ~r_exh;
  assign w_timeout   = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign grant       = r_grant;
  assign ack         = r_ack;
  assign err         = r_err;
  assign exhausted   = r_exh;
  assign core_sel    = r_core_sel;
  assign core_start  = r_start;
  assign counter_out = r_cnt_out;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = '0;
`ifdef CHACHA_SCHED_FIXED_PRIO_EN
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = SELW'(k);
      if (!w_any && w_elig[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
`else
    // Search starts just past the last owner so simultaneous requesters rotate.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = SELW'((32'(r_rr) + k) % NUM_REQ);
      if (!w_any && w_elig[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_next = S_START;
      S_START:   w_next = S_WAIT;
      S_WAIT:    if (core_done || w_timeout) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_exh      <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_err      <= '0;
      r_core_sel <= '0;
      r_start    <= 1'b0;
      r_cnt_out  <= '0;
      r_timer    <= '0;
`ifndef CHACHA_SCHED_FIXED_PRIO_EN
      r_rr       <= SELW'(NUM_REQ - 1);
`endif
      for (int unsigned i = 0; i < NUM_REQ; i++) r_ctr[i] <= COUNTER_INIT;
    end else begin
      r_state <= w_next;
      r_start <= 1'b0;
      r_ack   <= '0;
      r_err   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel      <= w_pick;
            r_grant    <= NUM_REQ'(1) << w_pick;
            r_core_sel <= w_pick;
            r_cnt_out  <= r_ctr[w_pick];
          end
        end
        S_START: begin
          r_start <= 1'b1;
          r_timer <= '0;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (core_done) begin
            r_ack[r_sel] <= 1'b1;
            if (last[r_sel]) begin
              r_ctr[r_sel] <= COUNTER_INIT;
            end else if (r_ctr[r_sel] == 32'hFFFF_FFFF) begin
              // Counter would wrap and reuse keystream: hold it and lock the requester out.
              r_exh[r_sel] <= 1'b1;
              r_err[r_sel] <= 1'b1;
            end else begin
              r_ctr[r_sel] <= r_ctr[r_sel] + 32'd1;
            end
          end else if (w_timeout) begin
            r_err[r_sel] <= 1'b1;
          end
        end
        S_RELEASE: begin
          r_grant   <= '0;
          r_cnt_out <= '0;
`ifndef CHACHA_SCHED_FIXED_PRIO_EN
          r_rr      <= r_sel;
`endif
        end
        default: ;
      endcase
      // Placed last so a clear overrides a same-cycle completion update.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (ctx_clear[i]) begin
          r_ctr[i] <= COUNTER_INIT;
          r_exh[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/chacha_core_sched.md
Name: chacha_core_sched

Overview:
- Round-robin scheduler that shares one ChaCha20 block core between NUM_REQ independent requesters.
- Each requester is, for example, a stream engine in the same style as the top-level block controller.
- Arbitrates block jobs, drives the core's start pulse and mux select, and keeps a per-requester 32-bit block counter.
- Guards against a hung core with a watchdog, and against counter wrap (keystream reuse) with a sticky exhaustion mask.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- COUNTER_INIT, 32'd1, per-requester counter value after reset, on clear, and after a last-block completion.
- TIMEOUT_CYCLES, 1024, WAIT-state cycles before the job is aborted; must be at least 2.
- Local parameter SELW = $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester block-job request; held until ack or err
- last  in  NUM_REQ  sampled with core_done: current block is the final block of the message
- ctx_clear  in  NUM_REQ  one-cycle pulse: counter to COUNTER_INIT, exhausted bit cleared
- grant  out  NUM_REQ  one-hot owner of the core; all zero when idle
- ack  out  NUM_REQ  one-cycle pulse: owner's block completed
- err  out  NUM_REQ  one-cycle pulse: owner's job timed out or its counter was exhausted
- exhausted  out  NUM_REQ  sticky per-requester counter-wrap flag
- core_sel  out  SELW  index of the owner; drives the core input/output mux
- core_start  out  1  one-cycle start pulse to the ChaCha20 core
- core_done  in  1  completion pulse from the core
- counter_out  out  32  block counter presented to the core for the owner
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer rr = NUM_REQ-1; every ctr[i] = COUNTER_INIT; timer = 0.
- Eligibility: eligible = req & ~exhausted.
- IDLE:
  - If eligible is nonzero, pick the first set bit searching from rr+1 upward, wrapping modulo NUM_REQ.
  - Register sel, then grant = onehot(sel), core_sel = sel, counter_out = ctr[sel]; go to START.
- START: core_start = 1 for exactly one cycle; timer cleared; go to WAIT. Latency from req rising in IDLE to core_start is 2 cycles.
- WAIT: timer increments every cycle.
  - core_done:
    - ack[sel] pulses.
    - ctr[sel] takes COUNTER_INIT if last[sel] is set, otherwise ctr+1.
    - If ctr[sel] == 32'hFFFFFFFF and last[sel] is clear: ctr is held, exhausted[sel] is set, err[sel] pulses in the same cycle as ack.
    - Go to RELEASE.
  - timer == TIMEOUT_CYCLES-1 with no core_done: err[sel] pulses, ctr unchanged, go to RELEASE.
  - core_done and timeout in the same cycle: done wins.
- RELEASE: grant is set to 0; rr <= sel; go to IDLE. The core therefore idles at least 1 cycle between jobs.
- core_done outside WAIT is ignored.
- req deasserted mid-job: the job still completes; ack/err is still issued.
- ctx_clear[i]: takes effect in any state. If it coincides with a done update to the same index, clear wins. It clears the exhausted bit but does not abort an in-flight job.
- counter_out holds its value from the grant until RELEASE; it is 0 in IDLE.
- Asynchronous reset mid-job: all state returns to reset values immediately; the core must share the same rst.
- Simultaneous requests are served in strict rotation; no requester waits more than NUM_REQ-1 jobs.

Optional Feature:
- Macro: CHACHA_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest eligible index always wins and rr is unused (it may be removed).
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Single requester: req=4'b0001 at cycle 0 → grant=0001 at cycle 1, core_start at cycle 2 with counter_out=1; core_done 10 cycles later → ack[0]; next job presents counter_out=2.
- Contention: req=4'b1111 held, core_done returned 5 cycles after each start → grant order 0,1,2,3,0; ack pulses in the same order.
- Last block: requester 2 at ctr=5, last[2]=1 with core_done → ack[2], ctr[2]=1, next counter_out=1.
- Timeout: TIMEOUT_CYCLES=16, core_done never sent → err[sel] 16 cycles after core_start; ctr unchanged; grant drops the next cycle.
- Wrap: force ctr[1]=32'hFFFFFFFF, last=0 → ack[1]+err[1] together, exhausted[1]=1, req[1] ignored; ctx_clear[1] → exhausted[1]=0, counter_out=1.
- Reset mid-WAIT: assert rst → grant=0, busy=0, core_start=0 immediately; all counters read back as COUNTER_INIT.
